alu_mc: RTL and testbench

- Next-generation execute unit for the rua RV32 core.
- Parametrised in XLEN; executes RV32I OP/OP-IMM and the M-extension (MUL/DIV/REM family).
- Adds a valid/ready handshake with backpressure and illegal-instruction flagging.
- Base ops complete in 1 cycle; multiply and divide are iterative over XLEN cycles.

---
 rtl/alu_mc.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: RV32 OP/OP-IMM + M-extension execute unit. Latency 1 for base ops, special cases and
// illegal ops; XLEN+1 for iterative MUL/DIV. Holds the result while out_ready is low; accepts back-to-back.
module alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            neg_q, neg_d;
    logic [2:0]      op_q, op_d;
    logic [SHW-1:0]  cnt_q, cnt_d;

    // ---------------- decode ----------------
    logic            accept;
    logic            dec_illegal;
    logic            is_m;
    logic            is_div;
    logic [SHW-1:0]  shamt;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign rd        = rd_q;
    assign illegal   = illegal_q;
    assign accept    = in_valid && in_ready;
    assign is_m      = (opcode == OPC_OP) && (funct7 == F7_MUL);
    assign is_div    = funct3[2];
    assign shamt     = rs2[SHW-1:0];

    always_comb begin
        dec_illegal = 1'b0;
        if (opcode == OPC_OP) begin
            case (funct7)
                F7_BASE, F7_MUL: dec_illegal = 1'b0;
                F7_ALT:          dec_illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
                default:         dec_illegal = 1'b1;
            endcase
        end else if (opcode == OPC_IMM) begin
            // Only the shift-immediates carry a real funct7; elsewhere it is immediate bits.
            if (funct3 == 3'b001) begin
                dec_illegal = (funct7 != F7_BASE);
            end else if (funct3 == 3'b101) begin
                dec_illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
            end
        end else begin
            dec_illegal = 1'b1;
        end
    end

    // ---------------- single-cycle ALU ----------------
    logic signed [XLEN-1:0] sra_res;
    logic        [XLEN-1:0] alu_res;

    assign sra_res = $signed(rs1) >>> shamt;

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = ((opcode == OPC_OP) && funct7[5]) ? rs1 - rs2 : rs1 + rs2;
            3'b001:  alu_res = rs1 << shamt;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            3'b100:  alu_res = rs1 ^ rs2;
            3'b101:  alu_res = funct7[5] ? sra_res : (rs1 >> shamt);
            3'b110:  alu_res = rs1 | rs2;
            default: alu_res = rs1 & rs2;
        endcase
    end

    // ---------------- M-extension setup ----------------
    logic            a_signed, b_signed;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] div_special;

    always_comb begin
        if (is_div) begin
            a_signed = !funct3[0];
            b_signed = !funct3[0];
        end else begin
            a_signed = (funct3[1:0] != 2'b11);
            b_signed = !funct3[1];
        end
    end

    assign neg_a    = a_signed && rs1[XLEN-1];
    assign neg_b    = b_signed && rs2[XLEN-1];
    assign mag_a    = neg_a ? -rs1 : rs1;
    assign mag_b    = neg_b ? -rs2 : rs2;
    assign div_zero = (rs2 == '0);
    assign div_ovf  = !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

    always_comb begin
        div_special = '0;
        if (div_zero) begin
            div_special = funct3[1] ? rs1 : '1;
        end else if (div_ovf) begin
            div_special = funct3[1] ? '0 : rs1;
        end
    end

    // ---------------- iteration step ----------------
    // Multiply: {hi,lo} shifts right, adding the multiplicand into hi when lo[0] is set.
    // Divide: {hi,lo} shifts left, hi is the partial remainder, quotient bits enter lo.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh, div_trial;
    logic              div_ok;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    logic [XLEN-1:0]   fin_res;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign div_sh    = {hi_q, lo_q[XLEN-1]};
    assign div_trial = div_sh - {1'b0, opnd_q};
    assign div_ok    = !div_trial[XLEN];

    always_comb begin
        if (op_q[2]) begin
            step_hi = div_ok ? div_trial[XLEN-1:0] : div_sh[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ok};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    assign prod     = {step_hi, step_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quot_fix = neg_q ? -step_lo : step_lo;
    assign rem_fix  = neg_q ? -step_hi : step_hi;

    always_comb begin
        fin_res = '0;
        case (op_q)
            3'b000:                 fin_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_res = quot_fix;
            default:                fin_res = rem_fix;
        endcase
    end

    // ---------------- control ----------------
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        op_d      = op_q;
        cnt_d     = cnt_q;

        case (state_q)
            BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(XLEN - 1)) begin
                    state_d   = DONE;
                    rd_d      = fin_res;
                    illegal_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            default: begin
                if (accept) begin
                    state_d   = DONE;
                    illegal_d = 1'b0;
                    if (dec_illegal) begin
                        rd_d      = '0;
                        illegal_d = 1'b1;
                    end else if (is_m) begin
                        if (is_div && (div_zero || div_ovf)) begin
                            rd_d = div_special;
                        end else begin
                            state_d = BUSY;
                            cnt_d   = '0;
                            hi_d    = '0;
                            lo_d    = is_div ? mag_a : mag_b;
                            opnd_d  = is_div ? mag_b : mag_a;
                            // Remainder takes the dividend's sign; everything else the XOR.
                            neg_d   = (is_div && funct3[1]) ? neg_a : (neg_a ^ neg_b);
                            op_d    = funct3;
                        end
                    end else begin
                        rd_d = alu_res;
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            op_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: hand-computed results, latencies, backpressure, reset and illegal decode.
module tb_alu_mc;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] F0  = 7'b0000000;
    localparam logic [6:0] FA  = 7'b0100000;
    localparam logic [6:0] FM  = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] rd;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    alu_mc #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Issues one op from IDLE, waits (bounded) for the result, then consumes it.
    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ill, output int lat);
        opcode = opc; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = rd;
        ill = illegal;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_rd: got %h want 00000000", rd); end
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_base();
        logic [31:0] res; logic ill; int lat;
        run_op(OP, 3'b000, F0, 32'd1, 32'd2, res, ill, lat);
        tests++; if (res !== 32'd3) begin fails++; $display("FAIL add_rd: got %h want 00000003", res); end
        tests++; if (ill !== 1'b0) begin fails++; $display("FAIL add_illegal: got %b want 0", ill); end
        tests++; if (lat != 1) begin fails++; $display("FAIL add_latency: got %0d want 1", lat); end
        run_op(OP, 3'b000, FA, 32'd1, 32'd2, res, ill, lat);
        tests++; if (res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sub_rd: got %h want ffffffff", res); end
        run_op(OP, 3'b101, FA, 32'h8000_0000, 32'd4, res, ill, lat);
        tests++; if (res !== 32'hF800_0000) begin fails++; $display("FAIL sra_rd: got %h want f8000000", res); end
        run_op(IMM, 3'b101, FA, 32'h8000_0000, 32'd4, res, ill, lat);
        tests++; if (res !== 32'hF800_0000) begin fails++; $display("FAIL srai_rd: got %h want f8000000", res); end
        run_op(OP, 3'b101, F0, 32'h8000_0000, 32'd4, res, ill, lat);
        tests++; if (res !== 32'h0800_0000) begin fails++; $display("FAIL srl_rd: got %h want 08000000", res); end
        run_op(OP, 3'b011, F0, 32'd1, 32'hFFFF_FFFF, res, ill, lat);
        tests++; if (res !== 32'd1) begin fails++; $display("FAIL sltu_rd: got %h want 00000001", res); end
        run_op(OP, 3'b010, F0, 32'd1, 32'hFFFF_FFFF, res, ill, lat);
        tests++; if (res !== 32'd0) begin fails++; $display("FAIL slt_rd: got %h want 00000000", res); end
        run_op(IMM, 3'b001, F0, 32'd1, 32'h0000_0021, res, ill, lat);
        tests++; if (res !== 32'd2) begin fails++; $display("FAIL slli_shamt_rd: got %h want 00000002", res); end
        run_op(OP, 3'b100, F0, 32'hA5A5_0F0F, 32'hFFFF_0000, res, ill, lat);
        tests++; if (res !== 32'h5A5A_0F0F) begin fails++; $display("FAIL xor_rd: got %h want 5a5a0f0f", res); end
        run_op(IMM, 3'b110, FA, 32'hA5A5_0F0F, 32'hFFFF_0000, res, ill, lat);
        tests++; if (res !== 32'hFFFF_0F0F) begin fails++; $display("FAIL ori_rd: got %h want ffff0f0f", res); end
        run_op(OP, 3'b111, F0, 32'hA5A5_0F0F, 32'hFFFF_0000, res, ill, lat);
        tests++; if (res !== 32'hA5A5_0000) begin fails++; $display("FAIL and_rd: got %h want a5a50000", res); end
        run_op(IMM, 3'b000, FA, 32'd10, 32'd3, res, ill, lat);
        tests++; if (res !== 32'd13) begin fails++; $display("FAIL addi_alt_rd: got %h want 0000000d", res); end
    endtask

    task automatic test_mul();
        logic [31:0] res; logic ill; int lat; logic rdy_seen;
        opcode = OP; funct3 = 3'b000; funct7 = FM; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        tests++; if (lat != 33) begin fails++; $display("FAIL mul_latency: got %0d want 33", lat); end
        tests++; if (rdy_seen !== 1'b0) begin fails++; $display("FAIL mul_busy_in_ready: got %b want 0", rdy_seen); end
        tests++; if (rd !== 32'd1) begin fails++; $display("FAIL mul_rd: got %h want 00000001", rd); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_op(OP, 3'b001, FM, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, ill, lat);
        tests++; if (res !== 32'd0) begin fails++; $display("FAIL mulh_rd: got %h want 00000000", res); end
        run_op(OP, 3'b011, FM, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, ill, lat);
        tests++; if (res !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mulhu_rd: got %h want fffffffe", res); end
        run_op(OP, 3'b010, FM, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, ill, lat);
        tests++; if (res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mulhsu_rd: got %h want ffffffff", res); end
        tests++; if (lat != 33) begin fails++; $display("FAIL mulhsu_latency: got %0d want 33", lat); end
        run_op(OP, 3'b000, FM, 32'd6, 32'hFFFF_FFF9, res, ill, lat);
        tests++; if (res !== 32'hFFFF_FFD6) begin fails++; $display("FAIL mul_neg_rd: got %h want ffffffd6", res); end
    endtask

    task automatic test_div();
        logic [31:0] res; logic ill; int lat;
        run_op(OP, 3'b100, FM, 32'hFFFF_FFF9, 32'd2, res, ill, lat);
        tests++; if (res !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_rd: got %h want fffffffd", res); end
        tests++; if (lat != 33) begin fails++; $display("FAIL div_latency: got %0d want 33", lat); end
        run_op(OP, 3'b110, FM, 32'hFFFF_FFF9, 32'd2, res, ill, lat);
        tests++; if (res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rem_rd: got %h want ffffffff", res); end
        tests++; if (lat != 33) begin fails++; $display("FAIL rem_latency: got %0d want 33", lat); end
        run_op(OP, 3'b101, FM, 32'd100, 32'd7, res, ill, lat);
        tests++; if (res !== 32'd14) begin fails++; $display("FAIL divu_rd: got %h want 0000000e", res); end
        run_op(OP, 3'b111, FM, 32'd100, 32'd7, res, ill, lat);
        tests++; if (res !== 32'd2) begin fails++; $display("FAIL remu_rd: got %h want 00000002", res); end
    endtask

    task automatic test_special();
        logic [31:0] res; logic ill; int lat;
        run_op(OP, 3'b101, FM, 32'd5, 32'd0, res, ill, lat);
        tests++; if (res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu_zero_rd: got %h want ffffffff", res); end
        tests++; if (lat != 1) begin fails++; $display("FAIL divu_zero_latency: got %0d want 1", lat); end
        run_op(OP, 3'b110, FM, 32'd5, 32'd0, res, ill, lat);
        tests++; if (res !== 32'd5) begin fails++; $display("FAIL rem_zero_rd: got %h want 00000005", res); end
        tests++; if (lat != 1) begin fails++; $display("FAIL rem_zero_latency: got %0d want 1", lat); end
        run_op(OP, 3'b100, FM, 32'h8000_0000, 32'hFFFF_FFFF, res, ill, lat);
        tests++; if (res !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_rd: got %h want 80000000", res); end
        tests++; if (lat != 1) begin fails++; $display("FAIL div_ovf_latency: got %0d want 1", lat); end
        run_op(OP, 3'b110, FM, 32'h8000_0000, 32'hFFFF_FFFF, res, ill, lat);
        tests++; if (res !== 32'd0) begin fails++; $display("FAIL rem_ovf_rd: got %h want 00000000", res); end
    endtask

    task automatic test_back_to_back();
        int lat;
        opcode = OP; funct3 = 3'b000; funct7 = F0; rs1 = 32'd10; rs2 = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (out_valid !== 1'b1 || rd !== 32'd30) begin
                fails++; $display("FAIL hold_cycle%0d: got valid=%b rd=%h want valid=1 rd=0000001e", i, out_valid, rd);
            end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready%0d: got %b want 0", i, in_ready); end
            @(posedge clk); #1;
        end
        rs1 = 32'd4; rs2 = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        tests++; if (out_valid !== 1'b1 || rd !== 32'd9) begin
            fails++; $display("FAIL b2b_rd: got valid=%b rd=%h want valid=1 rd=00000009", out_valid, rd);
        end
        lat = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] res; logic ill; int lat;
        run_op(7'b0000011, 3'b000, F0, 32'd1, 32'd2, res, ill, lat);
        tests++; if (ill !== 1'b1 || res !== 32'd0) begin fails++; $display("FAIL illegal_opcode: got ill=%b rd=%h want ill=1 rd=00000000", ill, res); end
        tests++; if (lat != 1) begin fails++; $display("FAIL illegal_latency: got %0d want 1", lat); end
        run_op(OP, 3'b001, FA, 32'd1, 32'd2, res, ill, lat);
        tests++; if (ill !== 1'b1) begin fails++; $display("FAIL illegal_f7_alt: got %b want 1", ill); end
        run_op(IMM, 3'b001, FM, 32'd1, 32'd2, res, ill, lat);
        tests++; if (ill !== 1'b1) begin fails++; $display("FAIL illegal_imm_m: got %b want 1", ill); end
        run_op(OP, 3'b000, F0, 32'd7, 32'd8, res, ill, lat);
        tests++; if (ill !== 1'b0 || res !== 32'd15) begin fails++; $display("FAIL illegal_clear: got ill=%b rd=%h want ill=0 rd=0000000f", ill, res); end
    endtask

    task automatic test_reset_busy();
        logic stale;
        opcode = OP; funct3 = 3'b100; funct7 = FM; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstbusy_out_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstbusy_in_ready: got %b want 1", in_ready); end
        tests++; if (rd !== 32'd0) begin fails++; $display("FAIL rstbusy_rd: got %h want 00000000", rd); end
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        tests++; if (stale !== 1'b0) begin fails++; $display("FAIL rstbusy_stale: got %b want 0", stale); end
    endtask

    initial begin
        test_reset();
        test_base();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_illegal();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
